vga_text_render: RTL and testbench
==================================

Name: vga_text_render

Overview:
- Text-mode pixel renderer that sits directly downstream of the VGA timing generator.
- Consumes hcount/vcount/bright/hsync/vsync and fetches character codes from a tile RAM, then glyph rows from a font ROM.
- Drives 8-bit RGB plus sync outputs, all delayed by one fixed pipeline latency so colour and sync stay aligned at the DAC/pins.
- Screen is 640x480 as 80x30 cells of 8x16 pixels.

Parameters:
- H_ACTIVE_START, 144, first hcount of the visible region (x = hcount - H_ACTIVE_START).
- BG_COLOR, 8'h00, background colour RRRGGGBB for glyph-0 pixels.
- COLS, 80, character cells per row (tile address stride).

Ports:
- clk  in  1  pixel clock (25 MHz domain of the timer)
- clear  in  1  asynchronous active-low reset
- hcount_in  in  10  horizontal position from timer
- vcount_in  in  10  vertical position from timer (0..479)
- bright_in  in  1  visible-region enable from timer
- hsync_in  in  1  active-low hsync from timer
- vsync_in  in  1  active-low vsync from timer
- tile_addr  out  12  tile RAM read address (row*COLS + col)
- tile_data  in  16  tile RAM read data, 1-cycle synchronous latency; [7:0] char code, [15:8] foreground RRRGGGBB
- glyph_addr  out  12  font ROM address {char[7:0], glyph_row[3:0]}
- glyph_data  in  8  font ROM data, 1-cycle synchronous latency; bit 7 = leftmost pixel
- cursor_col  in  7  cursor cell column (used only with the optional feature)
- cursor_row  in  5  cursor cell row (used only with the optional feature)
- rgb  out  8  pixel colour RRRGGGBB
- hsync  out  1  hsync_in delayed by LAT
- vsync  out  1  vsync_in delayed by LAT
- frame_cnt  out  8  free-running frame counter

Behaviour:
- Fixed latency LAT = 5 clk edges from timer inputs to rgb/hsync/vsync. Applies every cycle, with no stalls.
- Pipeline stages:
  - S1 (edge 1): register x = hcount_in - H_ACTIVE_START (10 bit, wraps harmlessly when not bright), y = vcount_in, bright, syncs. Drive tile_addr = (y[8:4] << 6) + (y[8:4] << 4) + x[9:3], 12-bit, max 2399.
  - S2 (edge 2): RAM samples tile_addr; carry x[2:0], y[3:0], bright, syncs.
  - S3 (edge 3): register glyph_addr = {tile_data[7:0], y[3:0]} and fg = tile_data[15:8]; carry sidebands.
  - S4 (edge 4): ROM samples glyph_addr; carry.
  - S5 (edge 5): pix = glyph_data[7 - x[2:0]]. rgb = bright ? (pix ? fg : BG_COLOR) : 8'h00. Register hsync and vsync.
- tile_addr and glyph_addr update every cycle regardless of bright; their values are don't-care outside the visible region, but never X after reset.
- frame_cnt increments by 1 on the cycle where the S1 vsync is 1 and vsync_in is 0 (falling edge). It wraps 8'hFF -> 8'h00.
- Reset (clear = 0, asynchronous):
  - All pipeline registers clear; rgb = 0, tile_addr = 0, glyph_addr = 0, frame_cnt = 0.
  - hsync = 1 and vsync = 1 (inactive). Internal sync pipeline registers also reset to 1.
- Reset released mid-frame: outputs show idle values (rgb 0, syncs 1) for the first 4 edges, then track inputs with LAT 5. No partial-frame correction.
- Simultaneous vsync falling edge and reset: reset wins, and frame_cnt stays 0.

Optional Feature:
- Macro: VGA_CURSOR_BLINK_EN.
- Defined:
  - S1 flags cur = (x[9:3] == cursor_col) && (y[8:4] == cursor_row). The flag is pipelined with the data.
  - In S5, when cur && frame_cnt[5] && bright, rgb is the bitwise inverse of the normal colour (~(pix ? fg : BG_COLOR)).
  - The cursor therefore blinks with a 64-frame period (about 1 s at 60 Hz).
- Undefined: cursor_col and cursor_row are ignored (no logic) and rgb follows the normal rule only.

Test Plan:
- Reset: hold clear = 0 with random inputs -> rgb = 0, hsync = vsync = 1, frame_cnt = 0, tile_addr = 0. Release -> first non-idle output on edge 5.
- Address map: hcount_in = 144+639, vcount_in = 479, bright = 1 -> tile_addr = 2399 one edge later. tile_data = 16'hE041 -> glyph_addr = 12'h41F two edges after that.
- Colour/latency: tile_data = 16'h1C41, glyph_data = 8'h80, bright = 1, x[2:0] = 0 -> rgb = 8'h1C exactly 5 edges after the input. With x[2:0] = 1 -> rgb = BG_COLOR.
- Blanking and sync alignment: bright_in = 0 and hsync_in = 0 for 96 cycles -> rgb = 0 and hsync = 0 for exactly the same 96 cycles, shifted by 5.
- Frame counter: drive 256 vsync falling edges -> frame_cnt steps 0..255 and then wraps to 0. A reset asserted on a falling-edge cycle leaves frame_cnt = 0.
- VGA_CURSOR_BLINK_EN: cursor at (3,2), pixel in cell (3,2) with frame_cnt = 8'h20 -> rgb inverted. With frame_cnt = 8'h1F -> normal. With the macro undefined -> always normal.

Source files
------------

// File: rtl/vga_text_render.sv
// vga_text_render -- 80x30 text-mode pixel renderer (8x16 cells, 640x480 visible)
// that sits directly behind the VGA timing generator. A five-stage pipeline fetches
// the character code from a tile RAM, then the glyph row from a font ROM, and selects
// one pixel. rgb, hsync and vsync all leave five clock edges after the timer inputs,
// so colour and sync stay aligned at the pins.
// Optional feature: define VGA_CURSOR_BLINK_EN to invert the pixels of the cursor cell
// while frame_cnt[5] is set (64-frame blink period).
module vga_text_render #(
    parameter int unsigned H_ACTIVE_START = 144,
    parameter logic [7:0]  BG_COLOR       = 8'h00,
    parameter int unsigned COLS           = 80
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [9:0]  hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        bright_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] tile_addr,
    input  logic [15:0] tile_data,
    output logic [11:0] glyph_addr,
    input  logic [7:0]  glyph_data,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [7:0]  rgb,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  frame_cnt
);

    // Visible-region x; wraps outside the visible window, which only produces
    // don't-care addresses while bright is low.
    logic [9:0] w_x;
    assign w_x = hcount_in - 10'(H_ACTIVE_START);

    // S1: position, sidebands
    logic [9:0] r_s1_x;
    logic [8:0] r_s1_y;
    logic       r_s1_bright;
    logic       r_s1_hs;
    logic       r_s1_vs;

    // S2: waiting on tile RAM
    logic [2:0] r_s2_xlo;
    logic [3:0] r_s2_ylo;
    logic       r_s2_bright;
    logic       r_s2_hs;
    logic       r_s2_vs;

    // S3: glyph address issued, foreground captured
    logic [11:0] r_glyph_addr;
    logic [7:0]  r_s3_fg;
    logic [2:0]  r_s3_xlo;
    logic        r_s3_bright;
    logic        r_s3_hs;
    logic        r_s3_vs;

    // S4: waiting on font ROM
    logic [7:0] r_s4_fg;
    logic [2:0] r_s4_xlo;
    logic       r_s4_bright;
    logic       r_s4_hs;
    logic       r_s4_vs;

    // S5: outputs
    logic [7:0] r_rgb;
    logic       r_s5_hs;
    logic       r_s5_vs;
    logic [7:0] r_frame_cnt;

    logic       w_pix;
    logic [7:0] w_color;
    logic [7:0] w_rgb_next;

`ifdef VGA_CURSOR_BLINK_EN
    logic r_s1_cur;
    logic r_s2_cur;
    logic r_s3_cur;
    logic r_s4_cur;

    // vcount never exceeds 479, so its top bit carries no information.
    logic w_unused;
    assign w_unused = vcount_in[9];
`else
    // Without the cursor feature the cursor inputs are intentionally left unconnected.
    logic w_unused;
    assign w_unused = ^{vcount_in[9], cursor_col, cursor_row};
`endif

    // Cell address: row * COLS + col, at most 29*80 + 79 = 2399 in the visible area.
    assign tile_addr  = 12'(r_s1_y[8:4]) * 12'(COLS) + 12'(r_s1_x[9:3]);
    assign glyph_addr = r_glyph_addr;
    assign rgb        = r_rgb;
    assign hsync      = r_s5_hs;
    assign vsync      = r_s5_vs;
    assign frame_cnt  = r_frame_cnt;

    // S1: capture timer position and sidebands; syncs reset to their inactive level (1).
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_bright <= 1'b0;
            r_s1_hs     <= 1'b1;
            r_s1_vs     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so each stage samples the previous stage's pre-edge value.
            r_s1_x      <= w_x;
            r_s1_y      <= vcount_in[8:0];
            r_s1_bright <= bright_in;
            r_s1_hs     <= hsync_in;
            r_s1_vs     <= vsync_in;
        end
    end

    // S2: carry the in-cell pixel coordinates while the tile RAM reads.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_s2_xlo    <= '0;
            r_s2_ylo    <= '0;
            r_s2_bright <= 1'b0;
            r_s2_hs     <= 1'b1;
            r_s2_vs     <= 1'b1;
        end else begin
            r_s2_xlo    <= r_s1_x[2:0];
            r_s2_ylo    <= r_s1_y[3:0];
            r_s2_bright <= r_s1_bright;
            r_s2_hs     <= r_s1_hs;
            r_s2_vs     <= r_s1_vs;
        end
    end

    // S3: form the font ROM address from the character code and glyph row.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_glyph_addr <= '0;
            r_s3_fg      <= '0;
            r_s3_xlo     <= '0;
            r_s3_bright  <= 1'b0;
            r_s3_hs      <= 1'b1;
            r_s3_vs      <= 1'b1;
        end else begin
            r_glyph_addr <= {tile_data[7:0], r_s2_ylo};
            r_s3_fg      <= tile_data[15:8];
            r_s3_xlo     <= r_s2_xlo;
            r_s3_bright  <= r_s2_bright;
            r_s3_hs      <= r_s2_hs;
            r_s3_vs      <= r_s2_vs;
        end
    end

    // S4: carry colour and pixel column while the font ROM reads.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_s4_fg     <= '0;
            r_s4_xlo    <= '0;
            r_s4_bright <= 1'b0;
            r_s4_hs     <= 1'b1;
            r_s4_vs     <= 1'b1;
        end else begin
            r_s4_fg     <= r_s3_fg;
            r_s4_xlo    <= r_s3_xlo;
            r_s4_bright <= r_s3_bright;
            r_s4_hs     <= r_s3_hs;
            r_s4_vs     <= r_s3_vs;
        end
    end

`ifdef VGA_CURSOR_BLINK_EN
    // Cursor flag: raised in S1 for pixels inside the cursor cell, then pipelined with the data.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_s1_cur <= 1'b0;
            r_s2_cur <= 1'b0;
            r_s3_cur <= 1'b0;
            r_s4_cur <= 1'b0;
        end else begin
            r_s1_cur <= (w_x[9:3] == cursor_col) && (vcount_in[8:4] == cursor_row);
            r_s2_cur <= r_s1_cur;
            r_s3_cur <= r_s2_cur;
            r_s4_cur <= r_s3_cur;
        end
    end
`endif

    // S5 pixel select: glyph bit 7 is the leftmost pixel; blanked outside the visible area.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch can be inferred.
        w_pix      = glyph_data[3'd7 - r_s4_xlo];
        w_color    = w_pix ? r_s4_fg : BG_COLOR;
        w_rgb_next = 8'h00;
        if (r_s4_bright) begin
            w_rgb_next = w_color;
`ifdef VGA_CURSOR_BLINK_EN
            if (r_s4_cur && r_frame_cnt[5]) begin
                w_rgb_next = ~w_color;
            end
`endif
        end
    end

    // S5: register colour and the matching syncs so they reach the pins together.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_rgb   <= 8'h00;
            r_s5_hs <= 1'b1;
            r_s5_vs <= 1'b1;
        end else begin
            r_rgb   <= w_rgb_next;
            r_s5_hs <= r_s4_hs;
            r_s5_vs <= r_s4_vs;
        end
    end

    // Frame counter: counts falling edges of the timer's vsync, wrapping at 8 bits.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_frame_cnt <= 8'h00;
        end else if (r_s1_vs && !vsync_in) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_text_render.sv
// tb_vga_text_render -- self-checking bench for vga_text_render.
// A behavioural model computes each pixel straight from screen geometry (cell = x/8,
// y/16; glyph bit 7 - x%8) using the bench's own tile RAM and font ROM contents; a
// compare process checks every cycle's outputs against it. Directed steps add literal
// expectations for reset, address mapping, latency, blanking, frame counting and cursor.
module tb_vga_text_render;

    localparam int         H0 = 144;
    localparam logic [7:0] BG = 8'h00;

    logic        clk        = 1'b0;
    logic        clear      = 1'b0;
    logic [9:0]  hcount_in  = '0;
    logic [9:0]  vcount_in  = '0;
    logic        bright_in  = 1'b0;
    logic        hsync_in   = 1'b1;
    logic        vsync_in   = 1'b1;
    logic [11:0] tile_addr;
    logic [15:0] tile_data  = '0;
    logic [11:0] glyph_addr;
    logic [7:0]  glyph_data = '0;
    logic [6:0]  cursor_col = 7'd3;
    logic [4:0]  cursor_row = 5'd2;
    logic [7:0]  rgb;
    logic        hsync;
    logic        vsync;
    logic [7:0]  frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_low    = 0;

    vga_text_render dut (
        .clk        (clk),
        .clear      (clear),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .bright_in  (bright_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .tile_addr  (tile_addr),
        .tile_data  (tile_data),
        .glyph_addr (glyph_addr),
        .glyph_data (glyph_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_cnt  (frame_cnt)
    );

    always #20 clk = ~clk;

    // External memories, one-cycle synchronous read latency.
    logic [15:0] tile_mem [0:4095];
    logic [7:0]  font_mem [0:4095];

    always @(posedge clk) begin
        tile_data  <= tile_mem[tile_addr];
        glyph_data <= font_mem[glyph_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0]  color;
        logic        bright;
        logic        cur;
        logic        hs;
        logic        vs;
        logic        live;
        logic [11:0] taddr;
        logic [11:0] gaddr;
    } exp_t;

    function automatic exp_t idle_entry();
        exp_t e;
        e.color = 8'h00; e.bright = 1'b0; e.cur = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
        e.live = 1'b0; e.taddr = '0; e.gaddr = '0;
        return e;
    endfunction

    function automatic exp_t model_pixel(input logic [9:0] h, input logic [9:0] v,
                                         input logic b, input logic hs, input logic vs,
                                         input logic [6:0] ccol, input logic [4:0] crow);
        exp_t e;
        int x, y, col, row;
        logic [15:0] t;
        logic [7:0]  g;
        x = (int'(h) + 1024 - H0) % 1024;
        y = int'(v);
        col = x / 8;
        row = (y / 16) % 32;
        e.taddr  = 12'(row * 80 + col);
        t        = tile_mem[e.taddr];
        e.gaddr  = 12'(int'(t[7:0]) * 16 + y % 16);
        g        = font_mem[e.gaddr];
        e.color  = g[7 - (x % 8)] ? t[15:8] : BG;
        e.cur    = (col == int'(ccol)) && (row == int'(crow));
        e.bright = b;
        e.hs     = hs;
        e.vs     = vs;
        e.live   = 1'b1;
        return e;
    endfunction

    // q[0..4] hold the inputs sampled at edges p-4..p when checked after edge p.
    exp_t       q[$];
    exp_t       e_head;
    logic [7:0] want;
    logic [7:0] m_fc      = 8'h00;
    logic [7:0] m_fc_prev = 8'h00;
    logic       m_last_vs = 1'b1;

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!clear) begin
            check("reset_rgb", rgb, 8'h00);
            check("reset_hsync", hsync, 1'b1);
            check("reset_vsync", vsync, 1'b1);
            check("reset_frame_cnt", frame_cnt, 8'h00);
            check("reset_tile_addr", tile_addr, 12'h000);
            check("reset_glyph_addr", glyph_addr, 12'h000);
            q.delete();
            for (int k = 0; k < 5; k++) q.push_back(idle_entry());
            m_fc      = 8'h00;
            m_fc_prev = 8'h00;
            m_last_vs = 1'b1;
        end else if (q.size() == 5) begin
            e_head = q[0];
            want   = e_head.bright ? e_head.color : 8'h00;
`ifdef VGA_CURSOR_BLINK_EN
            if (e_head.bright && e_head.cur && m_fc_prev[5]) want = ~e_head.color;
`endif
            check("rgb", rgb, want);
            check("hsync", hsync, e_head.hs);
            check("vsync", vsync, e_head.vs);
            check("frame_cnt", frame_cnt, m_fc);
            if (q[4].live) check("tile_addr", tile_addr, q[4].taddr);
            if (q[2].live) check("glyph_addr", glyph_addr, q[2].gaddr);
            void'(q.pop_front());
            q.push_back(model_pixel(hcount_in, vcount_in, bright_in, hsync_in, vsync_in,
                                    cursor_col, cursor_row));
            m_fc_prev = m_fc;
            if (m_last_vs && !vsync_in) m_fc = m_fc + 8'd1;
            m_last_vs = vsync_in;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int h, input int v, input logic b, input logic hs, input logic vs);
        @(posedge clk); #1;
        hcount_in = 10'(h);
        vcount_in = 10'(v);
        bright_in = b;
        hsync_in  = hs;
        vsync_in  = vs;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        clear = 1'b0; bright_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;
    endtask

    task automatic frame_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 1'b0, 1'b1, 1'b1);
            drive(0, 0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            tile_mem[i] = 16'(i * 29 + 7) ^ 16'(i << 9);
            font_mem[i] = 8'(i * 53 + 17);
        end
        tile_mem[0]       = 16'h1C41;
        tile_mem[163]     = 16'hE041;
        tile_mem[2399]    = 16'hE041;
        font_mem[12'h410] = 8'h80;

        // Reset held with random timer inputs.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            hcount_in = 10'($urandom_range(0, 799));
            vcount_in = 10'($urandom_range(0, 479));
            bright_in = 1'($urandom_range(0, 1));
            hsync_in  = 1'($urandom_range(0, 1));
            vsync_in  = 1'($urandom_range(0, 1));
            #1;
            check("rst_hold_rgb", rgb, 8'h00);
            check("rst_hold_tile_addr", tile_addr, 12'h000);
            check("rst_hold_syncs", {hsync, vsync}, 2'b11);
        end

        // Release with a known foreground pixel: idle for 4 edges, colour on edge 5.
        @(posedge clk); #1;
        clear = 1'b1; hcount_in = 10'(H0); vcount_in = 10'd0;
        bright_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #2;
            check("release_idle", rgb, 8'h00);
        end
        @(posedge clk); #2;
        check("release_first", rgb, 8'h1C);

        // Address map at the bottom-right visible pixel.
        drive(H0 + 639, 479, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #2;
        check("tile_addr_max", tile_addr, 12'd2399);
        repeat (2) @(posedge clk);
        #2 check("glyph_addr_map", glyph_addr, 12'h41F);

        // Colour and exact latency for a single-cycle pixel.
        repeat (6) drive(0, 0, 1'b0, 1'b1, 1'b1);
        drive(H0, 0, 1'b1, 1'b1, 1'b1);
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #2 check("colour_early", rgb, 8'h00);
        @(posedge clk); #2;
        check("colour_lat5", rgb, 8'h1C);
        @(posedge clk); #2;
        check("colour_after", rgb, 8'h00);
        drive(H0 + 1, 0, 1'b1, 1'b1, 1'b1);
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #2 check("colour_bg", rgb, BG);

        // Sweep along a text row, then random vectors (model-checked every cycle).
        for (int i = 0; i < 160; i++) drive(H0 + i, 37, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 799), $urandom_range(0, 479), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Blanking with hsync low for 96 cycles.
        repeat (6) drive(H0, 100, 1'b1, 1'b1, 1'b1);
        n_low = 0;
        for (int i = 0; i < 116; i++) begin
            if (i < 96) drive(H0 + i, 200, 1'b0, 1'b0, 1'b1);
            else        drive(H0 + i, 200, 1'b1, 1'b1, 1'b1);
            if (hsync == 1'b0) n_low++;
        end
        check("hsync_low_cycles", n_low, 96);

        // Frame counter: 255 edges, then wrap.
        pulse_reset();
        frame_pulses(255);
        @(posedge clk); #2;
        check("frame_cnt_ff", frame_cnt, 8'hFF);
        frame_pulses(1);
        @(posedge clk); #2;
        check("frame_cnt_wrap", frame_cnt, 8'h00);
        frame_pulses(1);
        @(posedge clk); #2;
        check("frame_cnt_one", frame_cnt, 8'h01);

        // Reset asserted on a vsync falling-edge cycle.
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        vsync_in = 1'b0; clear = 1'b0;
        #1 check("rst_on_fall_async", frame_cnt, 8'h00);
        @(posedge clk); #2;
        check("rst_on_fall_edge", frame_cnt, 8'h00);
        @(posedge clk); #1;
        clear = 1'b1; vsync_in = 1'b1;
        repeat (3) @(posedge clk);
        #2 check("rst_on_fall_after", frame_cnt, 8'h00);

        // Cursor cell (3,2) at frame 0x20 (blink phase on).
        pulse_reset();
        frame_pulses(32);
        drive(H0 + 24, 32, 1'b1, 1'b1, 1'b0);
        #1 check("frame_cnt_20", frame_cnt, 8'h20);
        drive(0, 0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
`ifdef VGA_CURSOR_BLINK_EN
        #2 check("cursor_on_phase", rgb, 8'h1F);
`else
        #2 check("cursor_on_phase", rgb, 8'hE0);
`endif

        // Same pixel at frame 0x1F (blink phase off): normal colour.
        pulse_reset();
        frame_pulses(31);
        drive(H0 + 24, 32, 1'b1, 1'b1, 1'b0);
        #1 check("frame_cnt_1f", frame_cnt, 8'h1F);
        drive(0, 0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #2 check("cursor_off_phase", rgb, 8'hE0);

        repeat (8) drive(0, 0, 1'b0, 1'b1, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(40 * 60000);
        $display("FAIL timeout simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
